// File: rtl/jk_mod_counter.sv
// Up/down modulo-N counter whose next state is expressed as per-bit JK excitation.
// j_vec/k_vec drive a downstream JK flip-flop bank; count is the reference state it must track.
module jk_mod_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] count_nxt;
    logic             clamp;
    logic             wrap_nxt;
    logic             load_err_nxt;

    // Out-of-range states (>= MODULUS) count as terminal when counting up so the next step recovers to 0.
    always_comb begin
        if (up) begin
            tc = ({1'b0, count} >= (MOD_EXT - 1'b1));
        end else begin
            tc = (count == '0);
        end
    end

    always_comb begin
        toggle[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            toggle[i] = toggle[i-1] & (up ? count[i-1] : ~count[i-1]);
        end
    end

    always_comb begin
        j_vec        = '0;
        k_vec        = '0;
        target       = '0;
        clamp        = 1'b0;
        wrap_nxt     = 1'b0;
        load_err_nxt = 1'b0;
        if (load) begin
            clamp        = ({1'b0, load_val} >= MOD_EXT);
            target       = clamp ? MAX_VAL : load_val;
            j_vec        = target;
            k_vec        = ~target;
            load_err_nxt = clamp;
        end else if (en) begin
            if (tc) begin
                target   = up ? '0 : MAX_VAL;
                j_vec    = target;
                k_vec    = ~target;
                wrap_nxt = 1'b1;
            end else begin
                j_vec = toggle;
                k_vec = toggle;
            end
        end
    end

    // Characteristic JK equation applied per bit: Q+ = J&~Q | ~K&Q.
    always_comb begin
        count_nxt = (j_vec & ~count) | (~k_vec & count);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            wrap     <= wrap_nxt;
            load_err <= load_err_nxt;
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MODULUS=10) with hand-computed expectations.
module tb_jk_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic [3:0] j_vec;
    logic [3:0] k_vec;
    logic       tc;
    logic       wrap;
    logic       load_err;

    int checks;
    int errors;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .j_vec    (j_vec),
        .k_vec    (k_vec),
        .tc       (tc),
        .wrap     (wrap),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;

        step();
        step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_tc", 32'(tc), 32'd0);

        // count up 12 clocks: 1..9,0,1,2
        reset = 1'b1;
        en    = 1'b1;
        up    = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("up_count", 32'(count), 32'(k % 10));
            check("up_wrap", 32'(wrap), (k == 10) ? 32'd1 : 32'd0);
            check("up_tc", 32'(tc), ((k % 10) == 9) ? 32'd1 : 32'd0);
        end

        // load 0 then count down through the wrap
        load     = 1'b1;
        load_val = 4'd0;
        step();
        check("ld0_count", 32'(count), 32'd0);
        load = 1'b0;
        up   = 1'b0;
        #1;
        check("dn_tc_at0", 32'(tc), 32'd1);
        check("dn_j_wrap", 32'(j_vec), 32'h9);
        check("dn_k_wrap", 32'(k_vec), 32'h6);
        step();
        check("dn_count9", 32'(count), 32'd9);
        check("dn_wrap9", 32'(wrap), 32'd1);
        check("dn_tc9", 32'(tc), 32'd0);
        step();
        check("dn_count8", 32'(count), 32'd8);
        check("dn_wrap8", 32'(wrap), 32'd0);
        step();
        check("dn_count7", 32'(count), 32'd7);

        // load 7 with en=1: load wins
        load     = 1'b1;
        load_val = 4'd7;
        #1;
        check("ld7_j", 32'(j_vec), 32'h7);
        check("ld7_k", 32'(k_vec), 32'h8);
        step();
        check("ld7_count", 32'(count), 32'd7);
        check("ld7_wrap", 32'(wrap), 32'd0);
        check("ld7_err", 32'(load_err), 32'd0);
        load = 1'b0;
        up   = 1'b1;
        step();
        check("ld7_up8", 32'(count), 32'd8);
        step();
        check("ld7_up9", 32'(count), 32'd9);
        check("ld7_tc9", 32'(tc), 32'd1);
        step();
        check("ld7_up0", 32'(count), 32'd0);
        check("ld7_wrap0", 32'(wrap), 32'd1);

        // out-of-range load clamps to 9
        load     = 1'b1;
        load_val = 4'd12;
        #1;
        check("ld12_j", 32'(j_vec), 32'h9);
        check("ld12_k", 32'(k_vec), 32'h6);
        step();
        check("ld12_count", 32'(count), 32'd9);
        check("ld12_err", 32'(load_err), 32'd1);
        check("ld12_wrap", 32'(wrap), 32'd0);
        load = 1'b0;
        en   = 1'b0;
        step();
        check("ld12_err_clr", 32'(load_err), 32'd0);
        check("ld12_hold", 32'(count), 32'd9);

        // toggle excitation from 3 and hold with en=0
        load     = 1'b1;
        load_val = 4'd3;
        step();
        check("ld3_count", 32'(count), 32'd3);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        #1;
        check("tog_j", 32'(j_vec), 32'h7);
        check("tog_k", 32'(k_vec), 32'h7);
        step();
        check("tog_count4", 32'(count), 32'd4);
        en = 1'b0;
        #1;
        check("hold_j", 32'(j_vec), 32'h0);
        check("hold_k", 32'(k_vec), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_count", 32'(count), 32'd4);
        end

        // down toggle from 4: bits 0..2 toggle
        en = 1'b1;
        up = 1'b0;
        #1;
        check("dtog_j", 32'(j_vec), 32'h7);
        step();
        check("dtog_count3", 32'(count), 32'd3);

        // asynchronous reset mid-cycle at count=6
        load     = 1'b1;
        load_val = 4'd6;
        up       = 1'b1;
        step();
        check("ld6_count", 32'(count), 32'd6);
        load = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_wrap", 32'(wrap), 32'd0);
        check("arst_err", 32'(load_err), 32'd0);
        step();
        check("arst_held", 32'(count), 32'd0);
        reset = 1'b1;
        #1;
        check("rel_count", 32'(count), 32'd0);
        step();
        check("rel_up1", 32'(count), 32'd1);
        step();
        check("rel_up2", 32'(count), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
